regfile_mp: RTL and testbench

Parametrised multi-port integer register file; the next-generation replacement for the single-write, two-read 64-bit file in the datapath. It provides NREAD asynchronous read ports, two synchronous write ports with fixed priority, a per-register busy scoreboard for the issue stage, and a sequenced post-reset clear. It sits between decode/issue (reads, reservations) and writeback (two retiring results per cycle).

---
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard and post-reset clear sweep
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NREAD*ADDR_W-1:0]   rd_addr,
   output logic [NREAD*DATA_W-1:0]   rd_data,
   output logic [NREAD-1:0]          rd_busy,
   input  logic                      wr0_en,
   input  logic [ADDR_W-1:0]         wr0_addr,
   input  logic [DATA_W-1:0]         wr0_data,
   input  logic                      wr1_en,
   input  logic [ADDR_W-1:0]         wr1_addr,
   input  logic [DATA_W-1:0]         wr1_data,
   input  logic                      rsv_en,
   input  logic [ADDR_W-1:0]         rsv_addr,
   output logic                      init_busy
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DEPTH-1:0]    busy_q, busy_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic run;
   logic wr0_ok, wr1_ok, rsv_ok;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign run    = (state_q == ST_RUN) && !reset;
   assign wr0_ok = run && wr0_en && !is_zero(wr0_addr);
   assign wr1_ok = run && wr1_en && !is_zero(wr1_addr);
   assign rsv_ok = run && rsv_en && !is_zero(rsv_addr);

   // State register; the array itself is never reset, the sweep clears it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
      mem_q <= mem_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Port 1 is applied after port 0 so it wins on a collision; reserve is last so it wins over a clear.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (state_q == ST_INIT) begin
         mem_d[cnt_q] = '0;
      end else begin
         if (wr0_ok) begin
            mem_d[wr0_addr]  = wr0_data;
            busy_d[wr0_addr] = 1'b0;
         end
         if (wr1_ok) begin
            mem_d[wr1_addr]  = wr1_data;
            busy_d[wr1_addr] = 1'b0;
         end
         if (rsv_ok) busy_d[rsv_addr] = 1'b1;
      end
   end

   always_comb begin
      init_busy = reset || (state_q == ST_INIT);
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              b;

      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         d = mem_q[ra];
         b = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
         if (wr1_ok && (wr1_addr == ra)) begin
            d = wr1_data;
            b = rsv_ok && (rsv_addr == ra);
         end else if (wr0_ok && (wr0_addr == ra)) begin
            d = wr0_data;
            b = rsv_ok && (rsv_addr == ra);
         end
`endif
         if (init_busy || is_zero(ra)) begin
            d = '0;
            b = 1'b0;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = d;
      assign rd_busy[k]                  = b;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - table-driven scoreboard bench for regfile_mp
module tb_regfile_mp;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 2;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic           clock = 1'b0;
   logic           reset;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]  rd_busy;
   logic           wr0_en, wr1_en, rsv_en;
   logic [AW-1:0]  wr0_addr, wr1_addr, rsv_addr;
   logic [DW-1:0]  wr0_data, wr1_data;
   logic           init_busy;

   always #5 clock = ~clock;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
      .clock(clock), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .init_busy(init_busy)
   );

   typedef struct {
      string         name;
      logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
      logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
      logic          re;  logic [AW-1:0] ra;
      logic [AW-1:0] q0a; logic [DW-1:0] q0d; logic q0b;
      logic [AW-1:0] q1a; logic [DW-1:0] q1d; logic q1b;
   } vec_t;

   typedef struct {
      string         name;
      logic [DW-1:0] d0; logic b0;
      logic [DW-1:0] d1; logic b1;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_miss = 0;

   function automatic vec_t mkv(input string name,
      input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
      input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
      input logic re, input logic [AW-1:0] ra,
      input logic [AW-1:0] q0a, input logic [DW-1:0] q0d, input logic q0b,
      input logic [AW-1:0] q1a, input logic [DW-1:0] q1d, input logic q1b);
      vec_t v;
      v.name = name;
      v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
      v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
      v.re = re; v.ra = ra;
      v.q0a = q0a; v.q0d = q0d; v.q0b = q0b;
      v.q1a = q1a; v.q1d = q1d; v.q1b = q1b;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
   endtask

   task automatic push_exp(input string name, input logic [DW-1:0] d0, input logic b0,
                           input logic [DW-1:0] d1, input logic b1);
      exp_t e;
      e.name = name; e.d0 = d0; e.b0 = b0; e.d1 = d1; e.b1 = b1;
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      chk({e.name, "_d0"}, rd_data[DW-1:0], e.d0);
      chk({e.name, "_b0"}, {63'd0, rd_busy[0]}, {63'd0, e.b0});
      chk({e.name, "_d1"}, rd_data[2*DW-1:DW], e.d1);
      chk({e.name, "_b1"}, {63'd0, rd_busy[1]}, {63'd0, e.b1});
   endtask

   // Caller sets up the cycle before the reset edge; counts init_busy cycles including the reset cycle.
   task automatic reset_count(output int n, output int rd_nonzero);
      n = 0;
      rd_nonzero = 0;
      reset = 1'b1;
      rd_addr = {5'd9, 5'd5};
      wr0_addr = 5'd5; wr0_data = 64'h77;
      @(negedge clock);
      if (init_busy) n++;
      if (rd_data != '0 || rd_busy != '0) rd_nonzero++;
      @(posedge clock);
      #1 reset = 1'b0;
      wr0_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!init_busy) break;
         n++;
         if (rd_data != '0 || rd_busy != '0) rd_nonzero++;
         wr0_en = (n < 30);
      end
      wr0_en = 1'b0;
   endtask

   initial begin
      int n, nz;
      reset = 1'b1;
      rd_addr = '0;
      wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
      wr0_data = '0; wr1_data = '0;
      idle();

      vecs.push_back(mkv("wr_r5",  1,5,64'hDEAD, 0,0,0, 0,0, 5,64'hDEAD,0, 0,0,0));
      vecs.push_back(mkv("wr_pri", 1,7,64'h1111, 1,7,64'h2222, 0,0, 7,64'h2222,0, 5,64'hDEAD,0));
      vecs.push_back(mkv("rsv9",   0,0,0, 0,0,0, 1,9, 9,0,1, 7,64'h2222,0));
      vecs.push_back(mkv("rsv_wr", 1,9,64'h55, 0,0,0, 1,9, 9,64'h55,1, 9,64'h55,1));
      vecs.push_back(mkv("wr_clr", 0,0,0, 1,9,64'h66, 0,0, 9,64'h66,0, 5,64'hDEAD,0));
      vecs.push_back(mkv("zero0",  1,0,64'hFFFF, 0,0,0, 1,0, 0,0,0, 0,0,0));
      vecs.push_back(mkv("zero1",  0,0,0, 1,0,64'hFFFF, 0,0, 0,0,0, 9,64'h66,0));
      vecs.push_back(mkv("dual",   1,10,64'hA5A5_A5A5_A5A5_A5A5, 1,11,64'h5A5A_5A5A_5A5A_5A5A, 0,0,
                         10,64'hA5A5_A5A5_A5A5_A5A5,0, 11,64'h5A5A_5A5A_5A5A_5A5A,0));
      vecs.push_back(mkv("rsv_oth", 1,13,64'h13, 0,0,0, 1,12, 12,0,1, 13,64'h13,0));
      vecs.push_back(mkv("clr12",  1,12,64'hC, 0,0,0, 0,0, 12,64'hC,0, 13,64'h13,0));
      vecs.push_back(mkv("top",    0,0,0, 1,31,64'hFFFF_0000_1234_5678, 0,0,
                         31,64'hFFFF_0000_1234_5678,0, 1,0,0));
      vecs.push_back(mkv("set3",   1,3,64'h1111, 0,0,0, 0,0, 3,64'h1111,0, 31,64'hFFFF_0000_1234_5678,0));
      vecs.push_back(mkv("rsv_w1", 0,0,0, 1,14,64'h14, 1,14, 14,64'h14,1, 12,64'hC,0));

      // Power-up: reset held one cycle, writes attempted during the sweep
      reset_count(n, nz);
      chk("init_cycles", 64'(n), 64'd33);
      chk("init_rd_zero", 64'(nz), 64'd0);
      chk("init_wr_ignored", rd_data[DW-1:0], 64'd0);

      foreach (vecs[i]) begin
         @(posedge clock); #1;
         wr0_en = vecs[i].w0e; wr0_addr = vecs[i].w0a; wr0_data = vecs[i].w0d;
         wr1_en = vecs[i].w1e; wr1_addr = vecs[i].w1a; wr1_data = vecs[i].w1d;
         rsv_en = vecs[i].re;  rsv_addr = vecs[i].ra;
         push_exp(vecs[i].name, vecs[i].q0d, vecs[i].q0b, vecs[i].q1d, vecs[i].q1b);
         @(posedge clock); #1;
         idle();
         rd_addr = {vecs[i].q1a, vecs[i].q0a};
         @(negedge clock);
         pop_cmp();
      end

      // Same-cycle write seen by a read: forwarded only in the bypass build
      @(posedge clock); #1;
      wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 64'hABCD;
      rd_addr = {5'd5, 5'd3};
      push_exp("byp_wr", BYP ? 64'hABCD : 64'h1111, 1'b0, 64'hDEAD, 1'b0);
      @(negedge clock);
      pop_cmp();
      @(posedge clock); #1;
      idle();
      push_exp("byp_after", 64'hABCD, 1'b0, 64'hDEAD, 1'b0);
      @(negedge clock);
      pop_cmp();
      @(posedge clock); #1;
      wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h3333;
      rsv_en = 1'b1; rsv_addr = 5'd3;
      push_exp("byp_rsv", BYP ? 64'h3333 : 64'hABCD, BYP, 64'hDEAD, 1'b0);
      @(negedge clock);
      pop_cmp();
      @(posedge clock); #1;
      idle();
      push_exp("byp_rsv_after", 64'h3333, 1'b1, 64'hDEAD, 1'b0);
      @(negedge clock);
      pop_cmp();

      // Reset from RUN, then again mid-sweep at counter 17
      @(posedge clock); #1;
      rsv_en = 1'b1; rsv_addr = 5'd20;
      @(posedge clock); #1;
      idle();
      reset = 1'b1;
      rd_addr = {5'd9, 5'd5};
      @(posedge clock); #1;
      reset = 1'b0;
      nz = 0;
      repeat (17) begin
         @(posedge clock); #1;
         if (rd_data != '0 || rd_busy != '0) nz++;
      end
      chk("mid_init_busy", {63'd0, init_busy}, 64'd1);
      chk("mid_rd_zero", 64'(nz), 64'd0);
      reset_count(n, nz);
      chk("mid_restart_cycles", 64'(n), 64'd33);
      chk("mid_restart_rd_zero", 64'(nz), 64'd0);
      rd_addr = {5'd20, 5'd31};
      push_exp("post_sweep_a", 64'd0, 1'b0, 64'd0, 1'b0);
      @(negedge clock);
      pop_cmp();
      @(posedge clock); #1;
      rd_addr = {5'd14, 5'd5};
      push_exp("post_sweep_b", 64'd0, 1'b0, 64'd0, 1'b0);
      @(negedge clock);
      pop_cmp();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
